param_load_counter: RTL and testbench

Parametrised loadable up/down counter, the next generation of the team's fixed 4-bit load counter. It adds configurable width and modulus, up/down direction, and wrap, saturate and one-shot modes. It also provides terminal-count, wrap and done flags. It sits in timer, sequencer and test-pattern paths wherever a presettable, bounded count is needed.

---
 rtl/param_load_counter_if.sv | 28 ++
 rtl/param_load_counter.sv | 112 +++++++++++
 tb/tb_param_load_counter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/param_load_counter_if.sv
// Control and status bundle for param_load_counter.
interface param_load_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             clear_i;
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic             en_i;
  logic             up_i;
  logic [1:0]       mode_i;
  logic [WIDTH-1:0] count_o;
  logic             tc_o;
  logic             wrap_o;
  logic             done_o;
  logic             ovf_o;

  // Drives the controls and watches the count and flags.
  modport master (
    output clear_i, load_i, load_val_i, en_i, up_i, mode_i,
    input  count_o, tc_o, wrap_o, done_o, ovf_o
  );

  // The counter itself.
  modport slave (
    input  clear_i, load_i, load_val_i, en_i, up_i, mode_i,
    output count_o, tc_o, wrap_o, done_o, ovf_o
  );
endinterface

// File: rtl/param_load_counter.sv
// Parametrised loadable up/down counter with wrap, saturate and one-shot
// modes, terminal-count, wrap and done flags.
// Optional feature macro: PARAM_LOAD_COUNTER_OVF_EN (sticky ovf_o register;
// when undefined ovf_o is tied low).
module param_load_counter #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] MOD_VAL = {WIDTH{1'b1}}
) (
  input logic                 clk,
  input logic                 reset,
  param_load_counter_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] wrap_val;
  logic [WIDTH-1:0] step_val;
  logic             at_term;

  assign mode     = mode_e'(bus.mode_i);
  // Terminal value depends on direction; a wrap lands on the opposite end.
  assign term_val = bus.up_i ? MOD_VAL : '0;
  assign wrap_val = bus.up_i ? '0 : MOD_VAL;
  assign at_term  = (count_q == term_val);
  assign step_val = bus.up_i ? count_q + WIDTH'(1) : count_q - WIDTH'(1);

  // Next count, wrap pulse and done flag; clear > load > enable > hold.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    done_d  = done_q;
    if (bus.clear_i) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (bus.load_i) begin
      count_d = (bus.load_val_i > MOD_VAL) ? MOD_VAL : bus.load_val_i;
      done_d  = 1'b0;
    end else if (bus.en_i && !done_q) begin
      case (mode)
        MODE_SAT: begin
          if (!at_term) count_d = step_val;
        end
        MODE_ONESHOT: begin
          if (!at_term) count_d = step_val;
          if (at_term || (step_val == term_val)) done_d = 1'b1;
        end
        default: begin
          if (at_term) begin
            count_d = wrap_val;
            wrap_d  = 1'b1;
          end else begin
            count_d = step_val;
          end
        end
      endcase
    end
  end

  // Count and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign bus.count_o = count_q;
  assign bus.wrap_o  = wrap_q;
  assign bus.done_o  = done_q;
  assign bus.tc_o    = at_term;

`ifdef PARAM_LOAD_COUNTER_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky flag for any attempted step past the terminal outside one-shot.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.clear_i) begin
      ovf_d = 1'b0;
    end else if (!bus.load_i && bus.en_i && !done_q &&
                 (mode != MODE_ONESHOT) && at_term) begin
      ovf_d = 1'b1;
    end
  end

  // Overflow register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign bus.ovf_o = ovf_q;
`else
  assign bus.ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_param_load_counter.sv
// Self-checking bench for param_load_counter (WIDTH=4, MOD_VAL=9).
module tb_param_load_counter;

  localparam int MOD = 9;
`ifdef PARAM_LOAD_COUNTER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  // Reference state kept as plain integers.
  int   m_count;
  bit   m_wrap, m_done, m_ovf;

  param_load_counter_if #(.WIDTH(4)) bus ();

  param_load_counter #(.WIDTH(4), .MOD_VAL(4'd9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_count = 0; m_wrap = 0; m_done = 0; m_ovf = 0;
  endtask

  // Apply one clock edge of the spec's rules to the reference state.
  task automatic model_edge();
    int dir, raw, target;
    dir    = bus.up_i ? 1 : -1;
    raw    = m_count + dir;
    target = bus.up_i ? MOD : 0;
    m_wrap = 0;
    if (bus.clear_i) begin
      model_reset();
    end else if (bus.load_i) begin
      m_count = (int'(bus.load_val_i) > MOD) ? MOD : int'(bus.load_val_i);
      m_done  = 0;
    end else if (bus.en_i && !m_done) begin
      case (bus.mode_i)
        2'b01: if (raw < 0 || raw > MOD) m_ovf = 1; else m_count = raw;
        2'b10: begin
          if (m_count != target) m_count = raw;
          if (m_count == target) m_done = 1;
        end
        default: begin
          if (raw < 0 || raw > MOD) begin
            m_ovf = 1; m_wrap = 1;
            m_count = (raw + MOD + 1) % (MOD + 1);
          end else m_count = raw;
        end
      endcase
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input bit clr, input bit ld, input int val,
                         input bit en, input bit up, input int mode);
    bus.clear_i = clr; bus.load_i = ld; bus.load_val_i = 4'(val);
    bus.en_i = en; bus.up_i = up; bus.mode_i = 2'(mode);
  endtask

  task automatic test_reset();
    reset = 0;
    set_ctl(0, 1, 5, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_checks++; if (bus.count_o !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count_o); end
    n_checks++; if ({bus.wrap_o, bus.done_o, bus.ovf_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {bus.wrap_o, bus.done_o, bus.ovf_o}); end
    reset = 1;
    tick();
    n_checks++; if (bus.count_o !== 4'd5) begin n_fail++; $display("FAIL first_edge_load got=%0d exp=5", bus.count_o); end
    set_ctl(0, 0, 0, 1, 1, 0);
    tick();
    n_checks++; if (bus.count_o !== 4'd6) begin n_fail++; $display("FAIL count_after_reset got=%0d exp=6", bus.count_o); end
    #3 reset = 0;
    #1;
    model_reset();
    n_checks++; if (bus.count_o !== 4'd0) begin n_fail++; $display("FAIL async_reset_count got=%0d exp=0", bus.count_o); end
    n_checks++; if ({bus.wrap_o, bus.done_o, bus.ovf_o} !== 3'b000) begin n_fail++; $display("FAIL async_reset_flags got=%b exp=000", {bus.wrap_o, bus.done_o, bus.ovf_o}); end
    set_ctl(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_load_priority();
    set_ctl(0, 1, 12, 0, 1, 0);
    tick();
    n_checks++; if (bus.count_o !== 4'd9) begin n_fail++; $display("FAIL load_clamp got=%0d exp=9", bus.count_o); end
    n_checks++; if (bus.tc_o !== 1'b1) begin n_fail++; $display("FAIL load_clamp_tc got=%b exp=1", bus.tc_o); end
    set_ctl(1, 1, 5, 1, 1, 0);
    tick();
    n_checks++; if (bus.count_o !== 4'd0) begin n_fail++; $display("FAIL clear_over_load got=%0d exp=0", bus.count_o); end
  endtask

  task automatic test_wrap();
    int exp_c[3] = '{9, 0, 1};
    bit exp_w[3] = '{0, 1, 0};
    set_ctl(0, 1, 8, 0, 1, 0);
    tick();
    set_ctl(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.count_o !== 4'(exp_c[i])) begin n_fail++; $display("FAIL wrap_up_count[%0d] got=%0d exp=%0d", i, bus.count_o, exp_c[i]); end
      n_checks++; if (bus.wrap_o !== exp_w[i]) begin n_fail++; $display("FAIL wrap_up_pulse[%0d] got=%b exp=%b", i, bus.wrap_o, exp_w[i]); end
    end
    set_ctl(0, 1, 0, 0, 0, 0);
    tick();
    n_checks++; if (bus.tc_o !== 1'b1) begin n_fail++; $display("FAIL down_tc_at_zero got=%b exp=1", bus.tc_o); end
    set_ctl(0, 0, 0, 1, 0, 0);
    tick();
    n_checks++; if (bus.count_o !== 4'd9 || bus.wrap_o !== 1'b1) begin n_fail++; $display("FAIL wrap_down got=%0d/%b exp=9/1", bus.count_o, bus.wrap_o); end
    set_ctl(0, 0, 0, 0, 0, 0);
    tick();
    n_checks++; if (bus.count_o !== 4'd9 || bus.wrap_o !== 1'b0) begin n_fail++; $display("FAIL wrap_down_hold got=%0d/%b exp=9/0", bus.count_o, bus.wrap_o); end
  endtask

  task automatic test_saturate();
    set_ctl(1, 0, 0, 0, 1, 1);
    tick();
    set_ctl(0, 1, 8, 0, 1, 1);
    tick();
    n_checks++; if (bus.tc_o !== 1'b0) begin n_fail++; $display("FAIL sat_tc_at_8 got=%b exp=0", bus.tc_o); end
    set_ctl(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (bus.count_o !== 4'd9 || bus.tc_o !== 1'b1 || bus.wrap_o !== 1'b0) begin n_fail++; $display("FAIL sat_step[%0d] count/tc/wrap got=%0d/%b/%b exp=9/1/0", i, bus.count_o, bus.tc_o, bus.wrap_o); end
    end
    n_checks++; if (bus.ovf_o !== OVF_EN) begin n_fail++; $display("FAIL sat_ovf got=%b exp=%b", bus.ovf_o, OVF_EN); end
  endtask

  task automatic test_oneshot();
    int exp_c[6] = '{2, 1, 0, 0, 0, 0};
    bit exp_d[6] = '{0, 0, 1, 1, 1, 1};
    set_ctl(1, 0, 0, 0, 0, 2);
    tick();
    set_ctl(0, 1, 3, 0, 0, 2);
    tick();
    set_ctl(0, 0, 0, 1, 0, 2);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) bus.up_i = 1;
      tick();
      n_checks++; if (bus.count_o !== 4'(exp_c[i]) || bus.done_o !== exp_d[i]) begin n_fail++; $display("FAIL oneshot[%0d] count/done got=%0d/%b exp=%0d/%b", i, bus.count_o, bus.done_o, exp_c[i], exp_d[i]); end
    end
    n_checks++; if (bus.ovf_o !== 1'b0) begin n_fail++; $display("FAIL oneshot_no_ovf got=%b exp=0", bus.ovf_o); end
    set_ctl(0, 1, 4, 1, 0, 2);
    tick();
    n_checks++; if (bus.count_o !== 4'd4 || bus.done_o !== 1'b0) begin n_fail++; $display("FAIL oneshot_rearm got=%0d/%b exp=4/0", bus.count_o, bus.done_o); end
    set_ctl(0, 0, 0, 1, 0, 2);
    tick();
    n_checks++; if (bus.count_o !== 4'd3 || bus.done_o !== 1'b0) begin n_fail++; $display("FAIL oneshot_resume got=%0d/%b exp=3/0", bus.count_o, bus.done_o); end
  endtask

  task automatic test_hold_and_reserved();
    bit en_seq[3] = '{1, 0, 1};
    int exp_c[3] = '{3, 3, 4};
    set_ctl(0, 1, 2, 0, 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_ctl(0, 0, 0, en_seq[i], 1, 0);
      tick();
      n_checks++; if (bus.count_o !== 4'(exp_c[i]) || bus.wrap_o !== 1'b0) begin n_fail++; $display("FAIL hold[%0d] count/wrap got=%0d/%b exp=%0d/0", i, bus.count_o, bus.wrap_o, exp_c[i]); end
    end
    set_ctl(0, 1, 9, 0, 1, 3);
    tick();
    set_ctl(0, 0, 0, 1, 1, 3);
    tick();
    n_checks++; if (bus.count_o !== 4'd0 || bus.wrap_o !== 1'b1) begin n_fail++; $display("FAIL reserved_mode_wrap got=%0d/%b exp=0/1", bus.count_o, bus.wrap_o); end
  endtask

  task automatic test_random();
    bit exp_tc;
    for (int i = 0; i < 400; i++) begin
      set_ctl(($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 10),
              int'($urandom_range(0, 15)), ($urandom_range(0, 99) < 75),
              ($urandom_range(0, 99) < 60), int'($urandom_range(0, 3)));
      tick();
      exp_tc = bus.up_i ? (m_count == MOD) : (m_count == 0);
      n_checks++; if (bus.count_o !== 4'(m_count)) begin n_fail++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, bus.count_o, m_count); end
      n_checks++; if (bus.wrap_o !== m_wrap) begin n_fail++; $display("FAIL rand_wrap[%0d] got=%b exp=%b", i, bus.wrap_o, m_wrap); end
      n_checks++; if (bus.done_o !== m_done) begin n_fail++; $display("FAIL rand_done[%0d] got=%b exp=%b", i, bus.done_o, m_done); end
      n_checks++; if (bus.ovf_o !== (m_ovf & OVF_EN)) begin n_fail++; $display("FAIL rand_ovf[%0d] got=%b exp=%b", i, bus.ovf_o, m_ovf & OVF_EN); end
      n_checks++; if (bus.tc_o !== exp_tc) begin n_fail++; $display("FAIL rand_tc[%0d] got=%b exp=%b", i, bus.tc_o, exp_tc); end
    end
  endtask

  initial begin
    clk = 0;
    reset = 0;
    n_checks = 0;
    n_fail = 0;
    model_reset();
    set_ctl(0, 0, 0, 0, 1, 0);
    test_reset();
    test_load_priority();
    test_wrap();
    test_saturate();
    test_oneshot();
    test_hold_and_reserved();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
